// File: rtl/hazard_stall_unit.sv
// Hazard and stall control for a 5-stage RV32I pipeline: operand forwarding, load-use stall,
// branch flush and whole-pipeline freeze while data memory is busy, plus debug event counters.
module hazard_stall_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rs1,
  input  logic [4:0]       id_ex_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_memread,
  input  logic             ex_mem_regwrite,
  input  logic [4:0]       ex_mem_rd,
  input  logic             mem_wb_regwrite,
  input  logic [4:0]       mem_wb_rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze, flush, load_use;

  // Forwarding select for one ALU operand; EX/MEM is the younger result and wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (ex_mem_regwrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == rs))
      return 2'b10;
    else if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(id_ex_rs1);
  assign fwd_b = fwd_sel(id_ex_rs2);

  // ---------------------------------------------------------------- state register
  // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------- next-state logic
  // NOTE: default assignment first so no path through the block leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (mem_busy) state_next = (TIMEOUT <= 1) ? ERROR : MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_busy)                   state_next = RUN;
        else if (wait_cnt == WAIT_LAST)  state_next = ERROR;
      end
      ERROR:   state_next = ERROR;
      default: state_next = RUN;
    endcase
  end

  // ---------------------------------------------------------------- output logic
  assign freeze   = (state != RUN) || mem_busy;
  assign flush    = !freeze && branch_taken;
  assign load_use = !freeze && !branch_taken && id_ex_memread && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (flush) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (load_use) begin
      // One bubble only: next cycle ID/EX holds the bubble with MemRead cleared.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_flush   = 1'b1;
    end
  end

  // ---------------------------------------------------------------- wait-state timer and error flag
  // wait_cnt equals the number of busy cycles already seen, so the TIMEOUT-th busy cycle sees TIMEOUT-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN:      wait_cnt <= mem_busy ? WAIT_W'(1) : '0;
        MEM_WAIT: if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 1'b1;
        default:  wait_cnt <= wait_cnt;
      endcase
      if (state_next == ERROR) mem_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (load_use && (stall_cnt  != '1)) stall_cnt  <= stall_cnt  + 1'b1;
      if (flush    && (flush_cnt  != '1)) flush_cnt  <= flush_cnt  + 1'b1;
      if (freeze   && (freeze_cnt != '1)) freeze_cnt <= freeze_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_stall_unit;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble}
  localparam logic [5:0] NORM  = 6'b110010;
  localparam logic [5:0] STALL = 6'b000110;
  localparam logic [5:0] FLUSH = 6'b111110;
  localparam logic [5:0] FRZ   = 6'b000001;

  typedef struct {
    logic       reset;
    logic [4:0] if_rs1, if_rs2, ex_rs1, ex_rs2, ex_rd;
    logic       memread, em_rw;
    logic [4:0] em_rd;
    logic       mw_rw;
    logic [4:0] mw_rd;
    logic       br, busy;
  } vin_t;

  typedef struct {
    logic [1:0]       fa, fb;
    logic [5:0]       ctl;
    logic             err;
    logic [CNT_W-1:0] s, f, z;
  } vexp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] if_id_rs1 = '0, if_id_rs2 = '0, id_ex_rs1 = '0, id_ex_rs2 = '0, id_ex_rd = '0;
  logic id_ex_memread = 1'b0, ex_mem_regwrite = 1'b0, mem_wb_regwrite = 1'b0;
  logic [4:0] ex_mem_rd = '0, mem_wb_rd = '0;
  logic branch_taken = 1'b0, mem_busy = 1'b0;
  logic [1:0] fwd_a, fwd_b;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

  int checks = 0;
  int errors = 0;
  vexp_t exp_q[$];
  vexp_t mon_x;
  int vec_no = 0;

  hazard_stall_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .mem_wb_bubble(mem_wb_bubble),
    .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int vec, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec %0d %s: got 0x%0h expected 0x%0h", vec, name, act, req);
    end
  endtask

  function automatic vin_t idle();
    vin_t v;
    v.reset = 1'b0; v.if_rs1 = '0; v.if_rs2 = '0; v.ex_rs1 = '0; v.ex_rs2 = '0; v.ex_rd = '0;
    v.memread = 1'b0; v.em_rw = 1'b0; v.em_rd = '0; v.mw_rw = 1'b0; v.mw_rd = '0;
    v.br = 1'b0; v.busy = 1'b0;
    return v;
  endfunction

  function automatic vexp_t e(input logic [1:0] fa, input logic [1:0] fb, input logic [5:0] ctl,
                              input logic err, input int s, input int f, input int z);
    vexp_t x;
    x.fa = fa; x.fb = fb; x.ctl = ctl; x.err = err;
    x.s = CNT_W'(s); x.f = CNT_W'(f); x.z = CNT_W'(z);
    return x;
  endfunction

  // Drive one cycle of stimulus just after the edge and queue what the monitor must see.
  task automatic run(input vin_t v, input vexp_t x);
    @(posedge clk);
    #1;
    reset = v.reset;
    if_id_rs1 = v.if_rs1; if_id_rs2 = v.if_rs2;
    id_ex_rs1 = v.ex_rs1; id_ex_rs2 = v.ex_rs2; id_ex_rd = v.ex_rd;
    id_ex_memread = v.memread;
    ex_mem_regwrite = v.em_rw; ex_mem_rd = v.em_rd;
    mem_wb_regwrite = v.mw_rw; mem_wb_rd = v.mw_rd;
    branch_taken = v.br; mem_busy = v.busy;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      vec_no++;
      check("fwd_a", vec_no, 16'(fwd_a), 16'(mon_x.fa));
      check("fwd_b", vec_no, 16'(fwd_b), 16'(mon_x.fb));
      check("ctl", vec_no,
            16'({pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble}),
            16'(mon_x.ctl));
      check("mem_err", vec_no, 16'(mem_err), 16'(mon_x.err));
      check("stall_cnt", vec_no, 16'(stall_cnt), 16'(mon_x.s));
      check("flush_cnt", vec_no, 16'(flush_cnt), 16'(mon_x.f));
      check("freeze_cnt", vec_no, 16'(freeze_cnt), 16'(mon_x.z));
    end
  end

  initial begin
    vin_t v;

    // Reset state, then idle.
    v = idle(); v.reset = 1'b1;       run(v, e(2'b00, 2'b00, NORM, 0, 0, 0, 0));
    v = idle();                       run(v, e(2'b00, 2'b00, NORM, 0, 0, 0, 0));

    // Forwarding: both stages match, EX/MEM wins.
    v = idle(); v.em_rw = 1; v.em_rd = 5; v.mw_rw = 1; v.mw_rd = 5; v.ex_rs1 = 5; v.ex_rs2 = 5;
    run(v, e(2'b10, 2'b10, NORM, 0, 0, 0, 0));
    // EX/MEM rd = x0 never forwards, MEM/WB takes over.
    v.em_rd = 0;                      run(v, e(2'b01, 2'b01, NORM, 0, 0, 0, 0));
    // Different sources per operand.
    v = idle(); v.em_rw = 1; v.em_rd = 3; v.mw_rw = 1; v.mw_rd = 4; v.ex_rs1 = 4; v.ex_rs2 = 3;
    run(v, e(2'b01, 2'b10, NORM, 0, 0, 0, 0));
    // RegWrite low on EX/MEM, MEM/WB rd = x0 against rs2 = x0.
    v = idle(); v.em_rw = 0; v.em_rd = 6; v.mw_rw = 1; v.mw_rd = 0; v.ex_rs1 = 6; v.ex_rs2 = 0;
    run(v, e(2'b00, 2'b00, NORM, 0, 0, 0, 0));

    // Load-use on rs2, then normal flow.
    v = idle(); v.memread = 1; v.ex_rd = 7; v.if_rs2 = 7;
    run(v, e(2'b00, 2'b00, STALL, 0, 0, 0, 0));
    v = idle();                       run(v, e(2'b00, 2'b00, NORM, 0, 1, 0, 0));
    // Load-use on rs1.
    v = idle(); v.memread = 1; v.ex_rd = 9; v.if_rs1 = 9;
    run(v, e(2'b00, 2'b00, STALL, 0, 1, 0, 0));
    // Load into x0 is not a hazard.
    v = idle(); v.memread = 1; v.ex_rd = 0; v.if_rs1 = 0;
    run(v, e(2'b00, 2'b00, NORM, 0, 2, 0, 0));

    // Branch overrides a same-cycle load-use.
    v = idle(); v.memread = 1; v.ex_rd = 7; v.if_rs2 = 7; v.br = 1;
    run(v, e(2'b00, 2'b00, FLUSH, 0, 2, 0, 0));
    v = idle();                       run(v, e(2'b00, 2'b00, NORM, 0, 2, 1, 0));

    // Freeze beats flush: three busy cycles with branch_taken high.
    v = idle(); v.busy = 1; v.br = 1;
    run(v, e(2'b00, 2'b00, FRZ, 0, 2, 1, 0));
    run(v, e(2'b00, 2'b00, FRZ, 0, 2, 1, 1));
    run(v, e(2'b00, 2'b00, FRZ, 0, 2, 1, 2));
    // Memory ready: still in MEM_WAIT this cycle, so frozen; three frozen cycles counted so far.
    v.busy = 0;                       run(v, e(2'b00, 2'b00, FRZ, 0, 2, 1, 3));
    v = idle();                       run(v, e(2'b00, 2'b00, NORM, 0, 2, 1, 4));

    // Timeout: the 4th busy cycle traps into ERROR.
    v = idle(); v.busy = 1;
    run(v, e(2'b00, 2'b00, FRZ, 0, 2, 1, 4));
    run(v, e(2'b00, 2'b00, FRZ, 0, 2, 1, 5));
    run(v, e(2'b00, 2'b00, FRZ, 0, 2, 1, 6));
    run(v, e(2'b00, 2'b00, FRZ, 0, 2, 1, 7));
    v = idle();                       run(v, e(2'b00, 2'b00, FRZ, 1, 2, 1, 8));
    v.br = 1;                         run(v, e(2'b00, 2'b00, FRZ, 1, 2, 1, 9));
    v = idle(); v.memread = 1; v.ex_rd = 7; v.if_rs1 = 7;
    run(v, e(2'b00, 2'b00, FRZ, 1, 2, 1, 10));
    // Reset out of ERROR.
    v = idle(); v.reset = 1;          run(v, e(2'b00, 2'b00, NORM, 0, 0, 0, 0));
    v = idle();                       run(v, e(2'b00, 2'b00, NORM, 0, 0, 0, 0));

    // Reset in the middle of MEM_WAIT returns to RUN.
    v = idle(); v.busy = 1;           run(v, e(2'b00, 2'b00, FRZ, 0, 0, 0, 0));
    v.reset = 1;                      run(v, e(2'b00, 2'b00, FRZ, 0, 0, 0, 0));
    v = idle();                       run(v, e(2'b00, 2'b00, NORM, 0, 0, 0, 0));

    // Saturation: 16 stalls leave stall_cnt at 15.
    for (int k = 0; k < 16; k++) begin
      v = idle(); v.memread = 1; v.ex_rd = 7; v.if_rs1 = 7;
      run(v, e(2'b00, 2'b00, STALL, 0, (k > 15) ? 15 : k, 0, 0));
    end
    v = idle();                       run(v, e(2'b00, 2'b00, NORM, 0, 15, 0, 0));

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
